// File: rtl/pipe_core.sv
// Four-stage (IF/ID/EX/WB) pipelined core: EX-stage forwarding, register-file
// write-through, jump flush with two-cycle penalty, global stall, saturating retire counter.
module pipe_core #(
  parameter int unsigned     DATA_W   = 8,
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [7:0]        imem_data,
  output logic              wb_valid,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int unsigned NREG    = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ifid_t;

  typedef struct packed {
    logic              valid;
    logic [1:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [PC_W-1:0]   pc;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [2:0]        rd;
    logic [DATA_W-1:0] data;
  } exwb_t;

  logic [PC_W-1:0]   pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  idex_t             idex_q, idex_d;
  exwb_t             exwb_q, exwb_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [CNT_W-1:0]  retire_q, retire_d;

  logic              commit;
  logic [2:0]        id_rd, id_rs;
  logic [DATA_W-1:0] id_rd_val, id_rs_val;
  logic [DATA_W-1:0] op_a, op_b, imm_ext, result;
  logic              jump;
  logic [PC_W-1:0]   jmp_target;

  assign commit = exwb_q.valid & exwb_q.write;

  // ID read: a value committing at this edge wins over the stale array entry
  always_comb begin
    id_rd     = ifid_q.instr[5:3];
    id_rs     = ifid_q.instr[2:0];
    id_rd_val = rf_q[id_rd];
    id_rs_val = rf_q[id_rs];
    if (commit && (exwb_q.rd == id_rd)) id_rd_val = exwb_q.data;
    if (commit && (exwb_q.rd == id_rs)) id_rs_val = exwb_q.data;
  end

  // EX: operands forwarded from EX/WB, ALU and jump target
  always_comb begin
    op_a    = idex_q.rd_val;
    op_b    = idex_q.rs_val;
    if (commit && (exwb_q.rd == idex_q.rd)) op_a = exwb_q.data;
    if (commit && (exwb_q.rd == idex_q.rs)) op_b = exwb_q.data;
    imm_ext = DATA_W'($signed(idex_q.rs));
    result  = '0;
    case (idex_q.op)
      OP_ADD:  result = op_a + op_b;
      OP_SUB:  result = op_a - op_b;
      OP_ADDI: result = op_a + imm_ext;
      default: result = '0;
    endcase
    jump       = idex_q.valid && (idex_q.op == OP_JMP);
    jmp_target = idex_q.pc + PC_W'($signed({idex_q.rd, idex_q.rs}));
  end

  // Next-state for the whole pipeline; a taken jump squashes IF/ID and ID/EX
  always_comb begin
    pc_d         = pc_q + PC_W'(1);

    ifid_d.valid = 1'b1;
    ifid_d.instr = imem_data;
    ifid_d.pc    = pc_q;

    idex_d.valid  = ifid_q.valid;
    idex_d.op     = ifid_q.instr[7:6];
    idex_d.rd     = id_rd;
    idex_d.rs     = id_rs;
    idex_d.rd_val = id_rd_val;
    idex_d.rs_val = id_rs_val;
    idex_d.pc     = ifid_q.pc;

    exwb_d.valid = idex_q.valid;
    exwb_d.write = idex_q.valid && (idex_q.op != OP_JMP);
    exwb_d.rd    = idex_q.rd;
    exwb_d.data  = result;

    if (jump) begin
      pc_d         = jmp_target;
      ifid_d.valid = 1'b0;
      idex_d.valid = 1'b0;
    end

    retire_d = retire_q;
    if (exwb_q.valid && (retire_q != {CNT_W{1'b1}})) retire_d = retire_q + CNT_W'(1);
  end

  // Pipeline and PC registers; stall freezes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ifid_q   <= '0;
      idex_q   <= '0;
      exwb_q   <= '0;
      retire_q <= '0;
    end else if (!stall) begin
      pc_q     <= pc_d;
      ifid_q   <= ifid_d;
      idex_q   <= idex_d;
      exwb_q   <= exwb_d;
      retire_q <= retire_d;
    end
  end

  // Register file, written from EX/WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (!stall && commit) begin
      rf_q[exwb_q.rd] <= exwb_q.data;
    end
  end

  assign imem_addr    = pc_q;
  assign wb_valid     = commit & ~stall;
  assign wb_rd        = exwb_q.rd;
  assign wb_data      = exwb_q.data;
  assign retire_count = retire_q;

endmodule

// File: doc/pipe_core.md
Name: pipe_core

Overview:
- Parametrised four-stage (IF, ID, EX, WB) pipelined core, successor to the fixed 8-bit three-register-stage datapath.
- Generalised data and PC widths, configurable reset vector.
- Adds operand forwarding, register-file write-through bypass, jump flush, global stall and a retire counter.
- Instruction memory is external with a combinational read; the register file is internal.

Parameters:
- DATA_W, 8, register/ALU width (>=4).
- PC_W, 8, program counter/instruction address width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, retire counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- stall  input  1  global freeze; 1 holds all state.
- imem_addr  output  PC_W  fetch address, equal to the PC register.
- imem_data  input  8  instruction at imem_addr, combinational.
- wb_valid  output  1  a register write commits this cycle.
- wb_rd  output  3  destination register of the committing write.
- wb_data  output  DATA_W  value being written.
- retire_count  output  CNT_W  number of retired instructions.

Behaviour:
- Instruction format: [7:6] opcode, [5:3] rd, [2:0] rs or imm3.
  - 00 ADD: rd <= rd + rs.
  - 01 SUB: rd <= rd - rs.
  - 10 ADDI: rd <= rd + sext(imm3), where imm3 ranges -4..3.
  - 11 JMP: pc <= pc_of_jmp + sext({rd,rs}), 6-bit signed offset; no register write.
- Arithmetic is modulo 2^DATA_W; PC arithmetic is modulo 2^PC_W (wraps).
- Reset (asynchronous, reset=0):
  - pc=RESET_PC.
  - All stage valid bits=0.
  - r0..r7=0.
  - wb_valid=0, wb_rd=0, wb_data=0, retire_count=0.
- Stage timing, with stall=0:
  - Edge 1: IF/ID captures imem_data and pc; pc advances by 1.
  - Edge 2: ID/EX captures the rd and rs register values plus the decoded fields.
  - Edge 3: EX/WB captures the result, and wb_* reflect it.
  - Edge 4: the register file is written.
  - First wb_valid occurs 3 edges after fetch.
- Forwarding into the EX operands:
  - If EX/WB is valid, is a write, and its wb_rd matches the operand register index, use wb_data.
  - Otherwise use the ID/EX captured value.
- Register-file bypass: an ID read of a register being written at the same edge returns the new value.
- Result: no stalls are needed for data hazards; back-to-back dependent instructions give correct results.
- Jump:
  - Resolved in EX when ID/EX is valid with opcode 11.
  - At that edge, pc <= target and the IF/ID and ID/EX valid bits are cleared (2-cycle penalty).
  - The JMP moves to WB with wb_valid=0.
  - Offset 0 produces a self-loop.
- Retire: retire_count increments by 1 each edge where EX/WB holds a valid instruction (including JMP). It saturates at all-ones.
- stall=1:
  - pc, all pipeline registers, the register file and retire_count hold.
  - wb_valid is forced to 0 so no duplicate commits are reported.
  - Stall has priority over a jump flush; the jump takes effect on the first unstalled edge.
- Bubbles (invalid stages) never write registers and never count.
- Reset asserted mid-operation clears everything immediately. The first fetch after release is at RESET_PC.

Test Plan:
- Reset, then program ADDI r1,3; ADDI r2,-1 -> wb_valid at edges 3 and 4 with (r1,3) and (r2,0xFF for DATA_W=8); retire_count=2.
- Forwarding: ADDI r1,3; ADD r1,r1; ADD r1,r1 back-to-back -> wb_data sequence 3, 6, 12 with no gaps.
- Bypass distance 2: ADDI r3,2; ADDI r4,1; SUB r3,r4 -> third commit r3=1.
- Jump at address 5 with offset -5 -> next fetched address 0; the two younger instructions (addresses 6 and 7) are never committed; retire_count excludes them.
- Stall held 3 cycles mid-stream -> wb_valid=0 during the stall; the commit sequence resumes identically; imem_addr remains constant.
- Assert reset while r1=12 and pc=9 -> immediately pc=RESET_PC, wb_*=0, retire_count=0; r1 reads 0 after release.
